// File: rtl/conv3x3_filter_1px.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : conv3x3_filter_1px                                                |
// | Brief  : Two-stage pipelined 3x3 signed convolution with runtime kernel,  |
// |          right shift and clamp/abs/offset post-processing.                |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module conv3x3_filter_1px #(
    parameter int DATA_WIDTH = 8,
    parameter int COEF_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in3x3_val,
    output logic                      in3x3_rdy,
    input  logic [9*DATA_WIDTH-1:0]   in3x3_data,
    input  logic                      in3x3_sof,
    input  logic                      in3x3_sol,
    input  logic                      in3x3_eol,
    input  logic                      in3x3_eof,
    input  logic [9*COEF_WIDTH-1:0]   cfg_coef,
    input  logic [3:0]                cfg_shift,
    input  logic [1:0]                cfg_mode,
    output logic                      out_val,
    input  logic                      out_rdy,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic                      out_sof,
    output logic                      out_sol,
    output logic                      out_eol,
    output logic                      out_eof
);
    localparam int PROD_W = DATA_WIDTH + COEF_WIDTH + 1;
    localparam int ACC_W  = DATA_WIDTH + COEF_WIDTH + 5;

    localparam logic [COEF_WIDTH-1:0]   c_km1 = COEF_WIDTH'(-1);
    localparam logic [COEF_WIDTH-1:0]   c_km2 = COEF_WIDTH'(-2);
    localparam logic [COEF_WIDTH-1:0]   c_k12 = COEF_WIDTH'(12);
    localparam logic [9*COEF_WIDTH-1:0] c_laplace =
        {c_km1, c_km2, c_km1, c_km2, c_k12, c_km2, c_km1, c_km2, c_km1};
    localparam logic signed [ACC_W-1:0] c_offset  = ACC_W'(2**(DATA_WIDTH-1));
    localparam logic signed [ACC_W-1:0] c_pix_max = ACC_W'(2**DATA_WIDTH - 1);

    logic                     w_accept, w_s1_rdy, w_s2_rdy, w_cfg_load;
    logic [9*COEF_WIDTH-1:0]  w_coef;
    logic [3:0]               w_shift;
    logic [1:0]               w_mode;
    logic signed [PROD_W-1:0] w_prod [9];
    logic signed [ACC_W-1:0]  w_sum, w_shifted, w_post;
    logic [DATA_WIDTH-1:0]    w_pix_out;

    logic [9*COEF_WIDTH-1:0]  coef_q, coef_d;
    logic [3:0]               shift_q, shift_d;
    logic [1:0]               mode_q, mode_d;
    logic                     s1_val_q, s1_val_d;
    logic signed [PROD_W-1:0] s1_prod_q [9];
    logic signed [PROD_W-1:0] s1_prod_d [9];
    logic [3:0]               s1_mark_q, s1_mark_d;
    logic [3:0]               s1_shift_q, s1_shift_d;
    logic [1:0]               s1_mode_q, s1_mode_d;
    logic                     out_val_q, out_val_d;
    logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;
    logic [3:0]               out_mark_q, out_mark_d;

    assign w_s2_rdy   = ~out_val_q | out_rdy;
    assign w_s1_rdy   = ~s1_val_q | w_s2_rdy;
    assign in3x3_rdy  = w_s1_rdy & ~rst;
    assign w_accept   = in3x3_val & in3x3_rdy;
    assign w_cfg_load = w_accept & in3x3_sof;

    // The sof beat itself must already use the freshly presented configuration.
    assign w_coef  = w_cfg_load ? cfg_coef  : coef_q;
    assign w_shift = w_cfg_load ? cfg_shift : shift_q;
    assign w_mode  = w_cfg_load ? cfg_mode  : mode_q;

    for (genvar gi = 0; gi < 9; gi++) begin : g_tap
        logic [DATA_WIDTH-1:0] w_pix;
        logic [COEF_WIDTH-1:0] w_k;
        assign w_pix = in3x3_data[(8-gi)*DATA_WIDTH +: DATA_WIDTH];
        assign w_k   = w_coef[(8-gi)*COEF_WIDTH +: COEF_WIDTH];
        assign w_prod[gi] = $signed({{(COEF_WIDTH+1){1'b0}}, w_pix}) *
                            $signed({{(DATA_WIDTH+1){w_k[COEF_WIDTH-1]}}, w_k});
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < 9; i++) begin
            w_sum = w_sum + $signed({{(ACC_W-PROD_W){s1_prod_q[i][PROD_W-1]}}, s1_prod_q[i]});
        end
        w_shifted = w_sum >>> s1_shift_q;
        case (s1_mode_q)
            2'd1:    w_post = w_shifted[ACC_W-1] ? -w_shifted : w_shifted;
            2'd2:    w_post = w_shifted + c_offset;
            default: w_post = w_shifted;
        endcase
        if (w_post[ACC_W-1]) begin
            w_pix_out = '0;
        end else if (w_post > c_pix_max) begin
            w_pix_out = '1;
        end else begin
            w_pix_out = w_post[DATA_WIDTH-1:0];
        end
    end

    always_comb begin
        coef_d     = coef_q;
        shift_d    = shift_q;
        mode_d     = mode_q;
        s1_val_d   = s1_val_q;
        s1_prod_d  = s1_prod_q;
        s1_mark_d  = s1_mark_q;
        s1_shift_d = s1_shift_q;
        s1_mode_d  = s1_mode_q;
        out_val_d  = out_val_q;
        out_data_d = out_data_q;
        out_mark_d = out_mark_q;
        if (w_cfg_load) begin
            coef_d  = cfg_coef;
            shift_d = cfg_shift;
            mode_d  = cfg_mode;
        end
        if (w_s1_rdy) begin
            s1_val_d = w_accept;
        end
        if (w_accept) begin
            s1_prod_d  = w_prod;
            s1_mark_d  = {in3x3_sof, in3x3_sol, in3x3_eol, in3x3_eof};
            s1_shift_d = w_shift;
            s1_mode_d  = w_mode;
        end
        if (w_s2_rdy) begin
            out_val_d = s1_val_q;
            if (s1_val_q) begin
                out_data_d = w_pix_out;
                out_mark_d = s1_mark_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coef_q     <= c_laplace;
            shift_q    <= '0;
            mode_q     <= '0;
            s1_val_q   <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                s1_prod_q[i] <= '0;
            end
            s1_mark_q  <= '0;
            s1_shift_q <= '0;
            s1_mode_q  <= '0;
            out_val_q  <= 1'b0;
            out_data_q <= '0;
            out_mark_q <= '0;
        end else begin
            coef_q     <= coef_d;
            shift_q    <= shift_d;
            mode_q     <= mode_d;
            s1_val_q   <= s1_val_d;
            s1_prod_q  <= s1_prod_d;
            s1_mark_q  <= s1_mark_d;
            s1_shift_q <= s1_shift_d;
            s1_mode_q  <= s1_mode_d;
            out_val_q  <= out_val_d;
            out_data_q <= out_data_d;
            out_mark_q <= out_mark_d;
        end
    end

    assign out_val  = out_val_q;
    assign out_data = out_data_q;
    assign {out_sof, out_sol, out_eol, out_eof} = out_mark_q;

endmodule
`default_nettype wire

// File: tb/tb_conv3x3_filter_1px.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_conv3x3_filter_1px                                             |
// | Brief  : Directed and backpressure bench with an arithmetic reference.    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_conv3x3_filter_1px;
    localparam int DW = 8;
    localparam int CW = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in3x3_val = 1'b0;
    logic            in3x3_rdy;
    logic [9*DW-1:0] in3x3_data = '0;
    logic            in3x3_sof = 1'b0, in3x3_sol = 1'b0, in3x3_eol = 1'b0, in3x3_eof = 1'b0;
    logic [9*CW-1:0] cfg_coef = '0;
    logic [3:0]      cfg_shift = '0;
    logic [1:0]      cfg_mode = '0;
    logic            out_val;
    logic            out_rdy = 1'b1;
    logic [DW-1:0]   out_data;
    logic            out_sof, out_sol, out_eol, out_eof;

    conv3x3_filter_1px #(.DATA_WIDTH(DW), .COEF_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .in3x3_val(in3x3_val), .in3x3_rdy(in3x3_rdy), .in3x3_data(in3x3_data),
        .in3x3_sof(in3x3_sof), .in3x3_sol(in3x3_sol), .in3x3_eol(in3x3_eol), .in3x3_eof(in3x3_eof),
        .cfg_coef(cfg_coef), .cfg_shift(cfg_shift), .cfg_mode(cfg_mode),
        .out_val(out_val), .out_rdy(out_rdy), .out_data(out_data),
        .out_sof(out_sof), .out_sol(out_sol), .out_eol(out_eol), .out_eof(out_eof)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         data;
        logic [3:0] mark;
        int         lit;
        int         acyc;
        bit         lat;
    } exp_t;

    exp_t q[$];
    int   mk[9];
    int   msh, mmd;
    int   cyc = 0;
    int   vectors = 0;
    int   errors = 0;
    int   cur_lit = -1;
    bit   lat_en = 1'b0;
    bit   bp_en = 1'b0;

    localparam int LAP[9] = '{-1, -2, -1, -2, 12, -2, -1, -2, -1};

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int model(input int pix[9], input int k[9], input int sh, input int md);
        int s;
        s = 0;
        for (int i = 0; i < 9; i++) s += pix[i] * k[i];
        s = s >>> sh;
        if (md == 1 && s < 0) s = -s;
        else if (md == 2) s += 2**(DW-1);
        if (s < 0) s = 0;
        if (s > 2**DW - 1) s = 2**DW - 1;
        return s;
    endfunction

    function automatic logic [9*CW-1:0] pack_coef(input int k[9]);
        logic [9*CW-1:0] r;
        r = '0;
        for (int i = 0; i < 9; i++) r[(8-i)*CW +: CW] = CW'(k[i]);
        return r;
    endfunction

    // Reference model and compare process; everything here is sampled mid-cycle.
    always @(negedge clk) begin : mon
        exp_t e;
        int   pix[9];
        cyc++;
        if (rst) begin
            q.delete();
            for (int i = 0; i < 9; i++) mk[i] = LAP[i];
            msh = 0;
            mmd = 0;
            chk("rdy_in_reset", int'(in3x3_rdy), 0);
        end else begin
            chk("rdy_vs_occupancy", int'(in3x3_rdy), (q.size() == 2 && !out_rdy) ? 0 : 1);
            if (out_val && out_rdy) begin
                if (q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL spurious_output: out_data=%0d, expected no output beat", out_data);
                end else begin
                    e = q.pop_front();
                    chk("out_data_vs_model", int'(out_data), e.data);
                    chk("markers", int'({out_sof, out_sol, out_eol, out_eof}), int'(e.mark));
                    if (e.lit >= 0) chk("out_data_literal", int'(out_data), e.lit);
                    if (e.lat) chk("latency", cyc - e.acyc, 2);
                end
            end
            if (in3x3_val && in3x3_rdy) begin
                if (in3x3_sof) begin
                    for (int i = 0; i < 9; i++) mk[i] = int'($signed(cfg_coef[(8-i)*CW +: CW]));
                    msh = int'(cfg_shift);
                    mmd = int'(cfg_mode);
                end
                for (int i = 0; i < 9; i++) pix[i] = int'(in3x3_data[(8-i)*DW +: DW]);
                e.data = model(pix, mk, msh, mmd);
                e.mark = {in3x3_sof, in3x3_sol, in3x3_eol, in3x3_eof};
                e.lit  = cur_lit;
                e.acyc = cyc;
                e.lat  = lat_en;
                q.push_back(e);
            end
        end
    end

    always @(posedge clk) begin
        if (bp_en) begin
            #1;
            out_rdy = ($urandom_range(0, 1) == 1);
        end
    end

    task automatic send(input int pix[9], input bit sof, input bit sol, input bit eol,
                        input bit eof, input int lit);
        int t;
        for (int i = 0; i < 9; i++) in3x3_data[(8-i)*DW +: DW] = DW'(pix[i]);
        {in3x3_sof, in3x3_sol, in3x3_eol, in3x3_eof} = {sof, sol, eol, eof};
        cur_lit   = lit;
        in3x3_val = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            if (in3x3_rdy) break;
            t++;
            if (t > 500) begin
                vectors++;
                errors++;
                $display("FAIL accept_timeout: in3x3_rdy stayed 0, expected 1 within 500 cycles");
                break;
            end
        end
        @(posedge clk);
        #1;
        in3x3_val = 1'b0;
        {in3x3_sof, in3x3_sol, in3x3_eol, in3x3_eof} = 4'b0;
        cur_lit = -1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("drain_pending_beats", q.size(), 0);
    endtask

    int c10[9]  = '{0, 0, 0, 0, 10, 0, 0, 0, 0};
    int c50[9]  = '{0, 0, 0, 0, 50, 0, 0, 0, 0};
    int a100[9] = '{100, 100, 100, 100, 100, 100, 100, 100, 100};
    int a200[9] = '{200, 200, 200, 200, 200, 200, 200, 200, 200};
    int n10[9]  = '{10, 10, 10, 10, 0, 10, 10, 10, 10};
    int ones[9] = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    int twos[9] = '{2, 2, 2, 2, 2, 2, 2, 2, 2};
    int m_mode[5]  = '{0, 1, 2, 2, 3};
    int m_shift[5] = '{0, 0, 0, 1, 0};
    int m_exp[5]   = '{0, 120, 8, 68, 0};

    initial begin
        int pix[9];
        cfg_coef = pack_coef(LAP);
        repeat (3) @(negedge clk);
        chk("reset_out_val", int'(out_val), 0);
        chk("reset_out_data", int'(out_data), 0);
        chk("reset_markers", int'({out_sof, out_sol, out_eol, out_eof}), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Reset-default Laplace kernel without any sof beat
        send(a100, 0, 0, 0, 0, 0);
        send(c10, 0, 0, 0, 0, 120);
        send(c50, 0, 0, 0, 0, 255);
        drain();

        // Back-to-back stream with latency checks
        lat_en = 1'b1;
        for (int b = 0; b < 16; b++) begin
            for (int i = 0; i < 9; i++) pix[i] = (b * 16 + i * 7) % 256;
            send(pix, b == 0, b == 0, b == 15, b == 15, -1);
        end
        drain();
        lat_en = 1'b0;

        // Configuration captured only on sof
        cfg_coef = pack_coef(ones);
        cfg_shift = 4'd3;
        cfg_mode = 2'd0;
        send(a200, 1, 1, 0, 0, 225);
        cfg_coef = pack_coef(twos);
        cfg_shift = 4'd0;
        cfg_mode = 2'd1;
        send(a200, 0, 0, 1, 1, 225);

        // Post-processing modes
        cfg_coef = pack_coef(LAP);
        for (int m = 0; m < 5; m++) begin
            cfg_mode = 2'(m_mode[m]);
            cfg_shift = 4'(m_shift[m]);
            send(n10, 1, 1, 1, 1, m_exp[m]);
        end
        drain();

        // Random backpressure
        bp_en = 1'b1;
        for (int b = 0; b < 1000; b++) begin
            if (b % 50 == 0 || $urandom_range(0, 9) == 0) begin
                for (int i = 0; i < 9; i++) cfg_coef[i*CW +: CW] = CW'($urandom_range(0, 31));
                cfg_shift = 4'($urandom_range(0, 15) % ($urandom_range(0, 1) == 1 ? 16 : 4));
                cfg_mode = 2'($urandom_range(0, 3));
            end
            for (int i = 0; i < 9; i++) pix[i] = $urandom_range(0, 255);
            send(pix, b % 50 == 0, b % 10 == 0, b % 10 == 9, b % 50 == 49, -1);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        bp_en = 1'b0;
        @(posedge clk);
        #2 out_rdy = 1'b1;
        drain();

        // Reset with both stages full and output stalled
        @(posedge clk);
        #1 out_rdy = 1'b0;
        cfg_coef = pack_coef(LAP);
        cfg_shift = 4'd0;
        cfg_mode = 2'd0;
        send(c10, 1, 1, 0, 0, -1);
        send(c10, 0, 0, 0, 0, -1);
        @(negedge clk);
        chk("stall_out_val", int'(out_val), 1);
        chk("stall_out_sof", int'(out_sof), 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_out_val", int'(out_val), 0);
        chk("async_rst_markers", int'({out_sof, out_sol, out_eol, out_eof}), 0);
        chk("async_rst_out_data", int'(out_data), 0);
        chk("async_rst_in_rdy", int'(in3x3_rdy), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        out_rdy = 1'b1;
        cfg_coef = pack_coef(ones);
        send(c10, 0, 0, 0, 0, 120);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
